kernel_sysid_checker: RTL and testbench

Avalon-MM read master that sits directly downstream of the kernel system-ID slave and consumes its `readdata`. On each start request it reads the ID word (address 0) and the timestamp word (address 1), compares both against expected values, and reports pass or fail with sticky result registers and saturating run/fail counters. Boot firmware and the board-bring-up LED logic use it to confirm that the loaded FPGA image matches the software build before releasing the Nios core.

---
 rtl/kernel_sysid_checker.sv | 132 +++++++++++++
 tb/tb_kernel_sysid_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_sysid_checker.sv
// kernel_sysid_checker
// Avalon-MM read master that reads the system-ID slave's ID word (addr 0)
// and timestamp word (addr 1), compares both against build-time constants,
// and reports a sticky pass/fail result plus saturating run/fail counters.
// Every output is a register, so an asynchronous reset drops sys_read and
// clears all results and counters immediately.
module kernel_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1483930777,
  parameter int          READ_LATENCY = 0,
  parameter bit          AUTO_START   = 1'b1,
  parameter int          CNT_W        = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic             sys_address,
  output logic             sys_read,
  input  logic [31:0]      sys_readdata,
  output logic             busy,
  output logic             done,
  output logic             id_ok,
  output logic             ts_ok,
  output logic             pass,
  output logic [31:0]      id_word,
  output logic [31:0]      ts_word,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] fail_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_CMP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Read latency is at most 3, so a 2-bit wait counter covers every legal value.
  localparam logic [1:0]       LAT_LAST = 2'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t     state;
  logic [1:0] lat;
  logic       auto_pending;
  logic       id_match;
  logic       ts_match;

  // Compare the captured words; only consumed in CMP, after both captures.
  assign id_match = (id_word == EXPECTED_ID);
  assign ts_match = (ts_word == EXPECTED_TS);

  // Sequencer: one read per word with a fixed wait, then compare and report.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      lat          <= '0;
      auto_pending <= AUTO_START;
      sys_address  <= 1'b0;
      sys_read     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      pass         <= 1'b0;
      id_word      <= '0;
      ts_word      <= '0;
      run_count    <= '0;
      fail_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start || auto_pending) begin
            state        <= S_RD_ID;
            auto_pending <= 1'b0;
            lat          <= '0;
            sys_read     <= 1'b1;
            sys_address  <= 1'b0;
            busy         <= 1'b1;
            // Old verdict is withdrawn as soon as a new check begins.
            id_ok        <= 1'b0;
            ts_ok        <= 1'b0;
            pass         <= 1'b0;
          end
        end
        S_RD_ID: begin
          if (lat == LAT_LAST) begin
            id_word     <= sys_readdata;
            lat         <= '0;
            sys_address <= 1'b1;
            state       <= S_RD_TS;
          end else begin
            lat <= lat + 2'd1;
          end
        end
        S_RD_TS: begin
          if (lat == LAT_LAST) begin
            ts_word  <= sys_readdata;
            lat      <= '0;
            sys_read <= 1'b0;
            state    <= S_CMP;
          end else begin
            lat <= lat + 2'd1;
          end
        end
        S_CMP: begin
          id_ok <= id_match;
          ts_ok <= ts_match;
          pass  <= id_match && ts_match;
          if (run_count != CNT_MAX)
            run_count <= run_count + 1'b1;
          if (!(id_match && ts_match) && (fail_count != CNT_MAX))
            fail_count <= fail_count + 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          sys_read <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Bench for kernel_sysid_checker: three instances with different latency,
// auto-start and counter width, each fed by its own slave model that returns
// the word for the address presented L cycles earlier.
module tb_kernel_sysid_checker;

  localparam logic [31:0] EID = 32'd0;
  localparam logic [31:0] ETS = 32'h5872FC99;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        start = '0;
  logic [2:0]        sys_address, sys_read, busy, done, id_ok, ts_ok, pass;
  logic [2:0][31:0]  id_word, ts_word;
  logic [31:0]       rd0, rd1, rd2;
  logic [7:0]        rc0, fc0, rc1, fc1;
  logic [1:0]        rc2, fc2;

  logic [31:0] mem [3][2];
  logic [1:0]  ah [3];
  int          latv [3] = '{0, 2, 1};
  int          cmax [3] = '{255, 255, 3};
  int          run_m [3] = '{0, 0, 0};
  int          fail_m [3] = '{0, 0, 0};
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  // Address history so each slave can answer with the right delay.
  always @(posedge clock)
    for (int k = 0; k < 3; k++) ah[k] <= {ah[k][0], sys_address[k]};

  assign rd0 = mem[0][sys_address[0]];
  assign rd1 = mem[1][ah[1][1]];
  assign rd2 = mem[2][ah[2][0]];

  kernel_sysid_checker #(.READ_LATENCY(0), .AUTO_START(1'b1), .CNT_W(8)) u_a (
    .clock(clock), .reset_n(reset_n), .start(start[0]),
    .sys_address(sys_address[0]), .sys_read(sys_read[0]), .sys_readdata(rd0),
    .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
    .pass(pass[0]), .id_word(id_word[0]), .ts_word(ts_word[0]),
    .run_count(rc0), .fail_count(fc0));

  kernel_sysid_checker #(.READ_LATENCY(2), .AUTO_START(1'b0), .CNT_W(8)) u_b (
    .clock(clock), .reset_n(reset_n), .start(start[1]),
    .sys_address(sys_address[1]), .sys_read(sys_read[1]), .sys_readdata(rd1),
    .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
    .pass(pass[1]), .id_word(id_word[1]), .ts_word(ts_word[1]),
    .run_count(rc1), .fail_count(fc1));

  kernel_sysid_checker #(.READ_LATENCY(1), .AUTO_START(1'b0), .CNT_W(2)) u_c (
    .clock(clock), .reset_n(reset_n), .start(start[2]),
    .sys_address(sys_address[2]), .sys_read(sys_read[2]), .sys_readdata(rd2),
    .busy(busy[2]), .done(done[2]), .id_ok(id_ok[2]), .ts_ok(ts_ok[2]),
    .pass(pass[2]), .id_word(id_word[2]), .ts_word(ts_word[2]),
    .run_count(rc2), .fail_count(fc2));

  function automatic logic [31:0] rcv(input int k);
    case (k)
      0: return 32'(rc0);
      1: return 32'(rc1);
      default: return 32'(rc2);
    endcase
  endfunction

  function automatic logic [31:0] fcv(input int k);
    case (k)
      0: return 32'(fc0);
      1: return 32'(fc1);
      default: return 32'(fc2);
    endcase
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Word that matches its reference half the time, else differs in one bit.
  function automatic logic [31:0] pick(input logic [31:0] ref_w);
    if ($urandom_range(0, 1) == 0) return ref_w;
    return ref_w ^ (32'h1 << $urandom_range(0, 31));
  endfunction

  task automatic launch(input int k);
    @(negedge clock);
    start[k] = 1'b1;
    @(posedge clock);
  endtask

  // Called just after the edge into cycle 1 of a check; follows it to done.
  task automatic walk(input int k, input bit drop);
    int L = latv[k];
    int n = 4 + 2 * L;
    bit eid, ets;
    for (int c = 1; c <= n; c++) begin
      @(negedge clock);
      if (drop) start[k] = 1'b0;
      chk("busy", k, 32'(busy[k]), 32'(c <= 3 + 2 * L));
      chk("done", k, 32'(done[k]), 32'(c == n));
      chk("sys_read", k, 32'(sys_read[k]), 32'(c <= 2 + 2 * L));
      if (c <= 2 + 2 * L) chk("sys_address", k, 32'(sys_address[k]), 32'(c >= 2 + L));
      if (c == 1) chk("pass_clear", k, 32'(pass[k]), 32'd0);
    end
    eid = (mem[k][0] == EID);
    ets = (mem[k][1] == ETS);
    run_m[k]  = (run_m[k] + 1 > cmax[k]) ? cmax[k] : run_m[k] + 1;
    if (!(eid && ets)) fail_m[k] = (fail_m[k] + 1 > cmax[k]) ? cmax[k] : fail_m[k] + 1;
    chk("id_ok", k, 32'(id_ok[k]), 32'(eid));
    chk("ts_ok", k, 32'(ts_ok[k]), 32'(ets));
    chk("pass", k, 32'(pass[k]), 32'(eid && ets));
    chk("id_word", k, id_word[k], mem[k][0]);
    chk("ts_word", k, ts_word[k], mem[k][1]);
    chk("run_count", k, rcv(k), 32'(run_m[k]));
    chk("fail_count", k, fcv(k), 32'(fail_m[k]));
  endtask

  initial begin
    int k, pulses, last;
    for (int i = 0; i < 3; i++) begin
      mem[i][0] = EID;
      mem[i][1] = ETS;
    end

    // Reset state of every instance.
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk("rst_read", i, 32'(sys_read[i]), 32'd0);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_done", i, 32'(done[i]), 32'd0);
      chk("rst_pass", i, 32'(pass[i]), 32'd0);
      chk("rst_ts_word", i, ts_word[i], 32'd0);
      chk("rst_run", i, rcv(i), 32'd0);
    end

    // Auto-start on the first edge after release; done four cycles later.
    reset_n = 1'b1;
    @(posedge clock);
    walk(0, 1'b0);

    // Timestamp off by one.
    mem[0][1] = 32'h5872FC98;
    launch(0);
    walk(0, 1'b1);
    chk("ts_ok_directed", 0, 32'(ts_ok[0]), 32'd0);

    // Latency-2 instance with matching slave.
    launch(1);
    walk(1, 1'b1);

    // Randomized checks across all instances.
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 2);
      mem[k][0] = pick(EID);
      mem[k][1] = pick(ETS);
      launch(k);
      walk(k, 1'b1);
    end

    // start held high: a done pulse every 5 cycles, one run per pulse.
    mem[0][0] = EID;
    mem[0][1] = ETS;
    @(negedge clock);
    start[0] = 1'b1;
    @(posedge clock);
    pulses = 0;
    last = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (done[0]) begin
        if (last == 0) chk("first_done_cycle", 0, 32'(c), 32'd4);
        else chk("done_period", 0, 32'(c - last), 32'd5);
        pulses++;
        last = c;
      end
    end
    start[0] = 1'b0;
    chk("held_pulses", 0, 32'(pulses), 32'd4);
    for (int i = 0; i < pulses; i++) run_m[0] = (run_m[0] + 1 > cmax[0]) ? cmax[0] : run_m[0] + 1;
    chk("held_runs", 0, rcv(0), 32'(run_m[0]));
    @(negedge clock);
    chk("held_idle", 0, 32'(busy[0]), 32'd0);

    // Reset during the timestamp read of the latency-2 instance.
    mem[1][0] = 32'hA5A50001;
    launch(1);
    #1 start[1] = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    chk("pre_rst_read", 1, 32'(sys_read[1]), 32'd1);
    chk("pre_rst_addr", 1, 32'(sys_address[1]), 32'd1);
    chk("pre_rst_id_word", 1, id_word[1], 32'hA5A50001);
    reset_n = 1'b0;
    #1;
    chk("async_read", 1, 32'(sys_read[1]), 32'd0);
    chk("async_busy", 1, 32'(busy[1]), 32'd0);
    chk("async_id_word", 1, id_word[1], 32'd0);
    chk("async_run", 1, rcv(1), 32'd0);
    chk("async_run_a", 0, rcv(0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      run_m[i] = 0;
      fail_m[i] = 0;
    end
    mem[0][0] = EID;
    mem[0][1] = ETS;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    walk(0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("no_auto_read", 1, 32'(sys_read[1]), 32'd0);
      chk("no_auto_read", 2, 32'(sys_read[2]), 32'd0);
    end

    // Two-bit counters saturate at 3.
    for (int r = 0; r < 4; r++) begin
      mem[2][0] = EID ^ (32'h1 << $urandom_range(0, 31));
      mem[2][1] = pick(ETS);
      launch(2);
      walk(2, 1'b1);
      if (r >= 2) begin
        chk("sat_run", 2, rcv(2), 32'd3);
        chk("sat_fail", 2, fcv(2), 32'd3);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
